// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional feature macro used by this slice: SERIAL_SUB_OVF_EN (signed overflow flag).
package serial_sub_pkg;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width: enough to index bits 0..WIDTH-1, never less than one bit
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation for a single bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = ain - bin - bor_in, one bit per clock, LSB first.
// Valid/ready handshake on both sides, one operation in flight at a time.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output 'ovf'.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             bor_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic             d_bit;
    logic             b_out;

    // Single shared bit-slice; operands present their current LSB each cycle
    full_sub u_full_sub (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (b_out)
    );

    // Handshake flags come straight from the state so they are glitch-free
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Controller, operand shifters, result shifter and borrow chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= ain;
                        b_sh  <= bin;
                        br    <= bor_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= b_out;
                    if (cnt == LAST_BIT) begin
                        // a_sh[0]/b_sh[0] hold the operand MSBs on this final edge
                        borrow <= b_out;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
`endif
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=8) with directed, hand-computed vectors.
// SERIAL_SUB_OVF_EN, when defined, also enables checking of the ovf output.
module tb_serial_sub;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ain;
    logic [7:0] bin;
    logic       bor_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    exp_t sb[$];
    int   assert_count = 0;
    int   fail_count   = 0;
    int   cycle        = 0;

    serial_sub #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .bor_in    (bor_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // 100 MHz style clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle count used for latency/throughput checks
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        assert_count++;
        if (act !== expv) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: at the falling edge, a presented result that will be taken is compared to the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 32'(diff), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_diff", 32'(diff), 32'(e.diff));
                checkOutput("sb_borrow", 32'(borrow), 32'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
                checkOutput("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Offer operands until accepted, push the hand-computed expectation at the accepting edge
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bi,
                                 input logic [7:0] ed, input logic eb, input logic eo,
                                 input bit hold, output int acc_cycle);
        int n;
        ain      = a;
        bin      = b;
        bor_in   = bi;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            acc_cycle = -1;
            in_valid  = 1'b0;
        end else begin
            sb.push_back('{diff: ed, borrow: eb, ovf: eo});
            @(posedge clk);
            #1;
            acc_cycle = cycle;
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic waitOutValid(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_valid) checkOutput("drain_timeout", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int acc;
        int acc_prev;
        int n;
        logic [7:0] va [6];
        logic [7:0] vb [6];
        logic       vi [6];
        logic [7:0] vd [6];
        logic       vbr[6];
        logic       vo [6];

        // a, b, bor_in -> diff, borrow, ovf (hand-computed)
        va = '{8'h05, 8'h00, 8'h80, 8'h10, 8'h00, 8'h00};
        vb = '{8'h03, 8'h01, 8'h01, 8'h0F, 8'h00, 8'hFF};
        vi = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        vd = '{8'h02, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h00};
        vbr= '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
        vo = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        ain       = '0;
        bin       = '0;
        bor_in    = 1'b0;
        out_ready = 1'b1;
        #12;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_diff", 32'(diff), 32'd0);
        checkOutput("reset_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic operation with latency check
        applyStimulus(va[0], vb[0], vi[0], vd[0], vbr[0], vo[0], 1'b0, acc);
        waitOutValid(n);
        checkOutput("latency_edges", 32'(n), 32'd8);
        waitDrain();

        // Remaining directed vectors: wrap, signed overflow, zero, full wrap
        for (int i = 1; i < 6; i++) begin
            applyStimulus(va[i], vb[i], vi[i], vd[i], vbr[i], vo[i], 1'b0, acc);
            waitOutValid(n);
            waitDrain();
        end

        // Back-pressure: result held, load attempts ignored
        out_ready = 1'b0;
        applyStimulus(8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0, 1'b0, acc);
        waitOutValid(n);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            ain      = 8'hAA;
            bin      = 8'h55;
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_diff", 32'(diff), 32'hE2);
            checkOutput("bp_borrow", 32'(borrow), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain();
        checkOutput("hold_idle_diff", 32'(diff), 32'hE2);
        checkOutput("hold_idle_borrow", 32'(borrow), 32'd1);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of SHIFT discards the partial result
        applyStimulus(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_diff", 32'(diff), 32'd0);
        checkOutput("abort_borrow", 32'(borrow), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, acc);
        waitOutValid(n);
        waitDrain();

        // Back-to-back: in_valid held high, one accept per WIDTH+2 cycles
        applyStimulus(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, acc_prev);
        applyStimulus(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b1, acc);
        checkOutput("b2b_period_1", 32'(acc - acc_prev), 32'd10);
        acc_prev = acc;
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, acc);
        checkOutput("b2b_period_2", 32'(acc - acc_prev), 32'd10);
        waitOutValid(n);
        waitDrain();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
